// File: rtl/mod_enc_subshift.sv
// Iterative AES-256 SubBytes + ShiftRows stage.
// SBOX_LANES forward S-boxes are shared over 16/SBOX_LANES SUB cycles. One SHIFT
// cycle then registers the row-rotated state and pulses done for the downstream
// mixColumns stage. Byte k = 4*col + row sits at bits [8k +: 8].
module mod_enc_subshift #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] state_in,
    output logic         busy,
    output logic [127:0] state_out,
    output logic         done
);

    localparam int STEPS = 16 / SBOX_LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        SHIFT
    } state_t;

    state_t          state;
    logic [127:0]    work;
    logic [CW-1:0]   cnt;

    // Reject lane counts that do not divide the 16 state bytes evenly.
    generate
        if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
              SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_illegal_lanes
            $error("mod_enc_subshift: SBOX_LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 by shift-and-add.
    // NOTE: function locals are automatic, so blocking '=' is correct here; only registered state uses '<='.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: inverse as a^254 (0 maps to 0), then the affine map with 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] inv;
        p   = gf_mul(a, a);
        inv = p;
        for (int i = 0; i < 6; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
    function automatic logic [127:0] shift_rows(input logic [127:0] w);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = w[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        return o;
    endfunction

    // Control FSM, working state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            state_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= state_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SUB;
                    end
                end
                SUB: begin
                    for (int j = 0; j < SBOX_LANES; j++) begin
                        work[8*(int'(cnt)*SBOX_LANES+j) +: 8] <=
                            sbox(work[8*(int'(cnt)*SBOX_LANES+j) +: 8]);
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= SHIFT;
                end
                SHIFT: begin
                    state_out <= shift_rows(work);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_enc_subshift.sv
// Self-checking bench for mod_enc_subshift with three lane counts (4, 1, 16).
// The reference S-box is built by brute-force inverse search and the bitwise
// affine formula; the transform model works on a 4x4 byte matrix.
module tb_mod_enc_subshift;

    localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    localparam logic [127:0] FIPS_OUT = 128'he598271ef11141b8ae52b4e0305dbfd4;
    localparam logic [127:0] ALL_63   = {16{8'h63}};

    logic         clk;
    logic         reset;
    logic [2:0]   start;
    logic [127:0] state_in;
    logic [2:0]   busy;
    logic [2:0]   done;
    logic [127:0] sout [3];

    int errors = 0;
    int checks = 0;
    int lat [3] = '{5, 17, 2};
    string nm [3] = '{"L4", "L1", "L16"};
    logic [7:0] sbox_tab [256];

    mod_enc_subshift #(.SBOX_LANES(4)) dut4 (
        .clk(clk), .reset(reset), .start(start[0]), .state_in(state_in),
        .busy(busy[0]), .state_out(sout[0]), .done(done[0])
    );
    mod_enc_subshift #(.SBOX_LANES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .state_in(state_in),
        .busy(busy[1]), .state_out(sout[1]), .done(done[1])
    );
    mod_enc_subshift #(.SBOX_LANES(16)) dut16 (
        .clk(clk), .reset(reset), .start(start[2]), .state_in(state_in),
        .busy(busy[2]), .state_out(sout[2]), .done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything outruns its own cycle bounds.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int bit_i = 14; bit_i >= 8; bit_i--)
            if (prod[bit_i]) prod = prod ^ (16'h011b << (bit_i - 8));
        return prod[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^
                       inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_transform(input logic [127:0] din);
        logic [7:0]   m [4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = sbox_tab[din[8*(4*c+r) +: 8]];
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = m[r][(c+r)%4];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Start one transform on instance d; called 1 time unit after a rising edge.
    // Returns the result and the number of edges from the accept edge to done.
    task automatic run_one(input int d, input logic [127:0] din,
                           output logic [127:0] got, output int n);
        state_in = din;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        n = 0;
        while (done[d] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        got = sout[d];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int seen;
        reset = 1'b1;
        start = 3'b111;
        state_in = rand128();
        repeat (3) begin @(posedge clk); #1; end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (sout[d] !== 128'h0 || done[d] !== 1'b0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_%s: state_out=%h done=%b busy=%b, need 0/0/0",
                         nm[d], sout[d], done[d], busy[d]);
            end
        end
        reset = 1'b0;
        start = 3'b000;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done != 3'b000 || busy != 3'b000) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_start_ignored: %0d active cycles, need 0", seen);
        end
    endtask

    task automatic test_zero(input string tag);
        logic [127:0] got;
        int n;
        for (int d = 0; d < 3; d++) begin
            run_one(d, 128'h0, got, n);
            checks++;
            if (n != lat[d] || got !== ALL_63) begin
                errors++;
                $display("FAIL %s_zero_%s: latency=%0d out=%h, need %0d %h",
                         tag, nm[d], n, got, lat[d], ALL_63);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fips();
        logic [127:0] got;
        int n;
        for (int d = 0; d < 3; d++) begin
            run_one(d, FIPS_IN, got, n);
            checks++;
            if (n != lat[d] || got !== FIPS_OUT) begin
                errors++;
                $display("FAIL fips_%s: latency=%0d out=%h, need %0d %h",
                         nm[d], n, got, lat[d], FIPS_OUT);
            end
            @(posedge clk); #1;
            checks++;
            if (done[d] !== 1'b0 || sout[d] !== FIPS_OUT) begin
                errors++;
                $display("FAIL fips_pulse_%s: done=%b out=%h after pulse, need 0 %h",
                         nm[d], done[d], sout[d], FIPS_OUT);
            end
        end
        checks++;
        if (ref_transform(FIPS_IN) !== FIPS_OUT) begin
            errors++;
            $display("FAIL model_fips: model gives %h, need %h",
                     ref_transform(FIPS_IN), FIPS_OUT);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        int pulses;
        int busy_bad;
        state_in = FIPS_IN;
        start[0] = 1'b1;
        @(posedge clk); #1;
        busy_bad = 0;
        for (int k = 1; k <= 4; k++) begin
            if (busy[0] !== 1'b1) busy_bad++;
            state_in = rand128();
            start[0] = 1'b1;
            @(posedge clk); #1;
        end
        start[0] = 1'b0;
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL busy_high: busy low in %0d of 4 cycles, need 0", busy_bad);
        end
        n = 4;
        while (done[0] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 5 || sout[0] !== FIPS_OUT) begin
            errors++;
            $display("FAIL busy_ignore_result: latency=%0d out=%h, need 5 %h",
                     n, sout[0], FIPS_OUT);
        end
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL busy_ignore_single_done: %0d extra done pulses, need 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] got;
        int n;
        int held_bad;
        a = rand128();
        b = rand128();
        run_one(0, a, got, n);
        checks++;
        if (n != 5 || got !== ref_transform(a)) begin
            errors++;
            $display("FAIL b2b_first: latency=%0d out=%h, need 5 %h", n, got, ref_transform(a));
        end
        state_in = b;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        held_bad = 0;
        if (busy[0] !== 1'b1 || done[0] !== 1'b0 || sout[0] !== ref_transform(a)) held_bad++;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (done[0] !== 1'b0 || sout[0] !== ref_transform(a)) held_bad++;
        end
        checks++;
        if (held_bad != 0) begin
            errors++;
            $display("FAIL b2b_hold: %0d cycles without held first result, need 0", held_bad);
        end
        @(posedge clk); #1;
        checks++;
        if (done[0] !== 1'b1 || sout[0] !== ref_transform(b)) begin
            errors++;
            $display("FAIL b2b_second: done=%b out=%h, need 1 %h",
                     done[0], sout[0], ref_transform(b));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [127:0] din;
        logic [127:0] got;
        int n;
        for (int it = 0; it < 6; it++) begin
            for (int d = 0; d < 3; d++) begin
                din = rand128();
                run_one(d, din, got, n);
                checks++;
                if (n != lat[d] || got !== ref_transform(din)) begin
                    errors++;
                    $display("FAIL random_%s_%0d: in=%h latency=%0d out=%h, need %0d %h",
                             nm[d], it, din, n, got, lat[d], ref_transform(din));
                end
                if ($urandom_range(1, 0) == 1) begin @(posedge clk); #1; end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int seen;
        state_in = rand128();
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (sout[d] !== 128'h0 || done[d] !== 1'b0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL abort_outputs_%s: state_out=%h done=%b busy=%b, need 0/0/0",
                         nm[d], sout[d], done[d], busy[d]);
            end
        end
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1 || busy[0] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d active cycles after abort, need 0", seen);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 3'b000;
        state_in = '0;
        build_sbox();
        test_reset();
        test_zero("first");
        test_fips();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_abort();
        test_zero("rerun");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
